// File: rtl/inst_word_encoder.sv
// Packs RV32I instruction fields and an immediate into a 32-bit word, range-checks
// the immediate, and queues results with their byte write address in a 2-entry FIFO.
module inst_word_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           imm_sel,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } entry_t;

    logic [31:0]          enc_inst;
    logic                 enc_err;
    logic                 push;
    logic                 pop;
    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [31:0]          addr_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    entry_t               mem_q [2];
    entry_t               head;

    // Out-of-range immediates are still encoded from their truncated bits.
    always_comb begin
        enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
        case (imm_sel)
            IMM_I: begin
                enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err  = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            IMM_S: begin
                enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err  = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            IMM_B: begin
                enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err  = ((imm[31:12] != '0) && (imm[31:12] != '1)) || imm[0];
            end
            IMM_J: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err  = ((imm[31:20] != '0) && (imm[31:20] != '1)) || imm[0];
            end
            IMM_U: begin
                enc_inst = {imm[31:12], rd, opcode};
                enc_err  = (imm[11:0] != '0);
            end
            default: ;
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
                if (enc_err && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                addr_q   <= addr_q + 32'd4;
            end
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{inst: enc_inst, err: enc_err};
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_inst = out_valid ? head.inst : 32'd0;
    assign out_err  = out_valid ? head.err : 1'b0;
    assign out_addr = addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_inst_word_encoder.sv
// Bench for inst_word_encoder: directed cases plus randomized traffic checked against
// an arithmetic reference encoder and a queue-based FIFO/address/error-count model.
module tb_inst_word_encoder;

    typedef struct packed {
        logic [2:0]  sel;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    bundle_t     cur = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    exp_t        exp_q[$];
    logic [31:0] exp_addr = 32'd0;
    logic [7:0]  exp_errcnt = 8'd0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    inst_word_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm_sel(cur.sel), .opcode(cur.opc), .rd(cur.rd), .rs1(cur.rs1), .rs2(cur.rs2),
        .funct3(cur.f3), .funct7(cur.f7), .imm(cur.imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
    );

    // Reference encoder: fields placed by shift/mask arithmetic, ranges checked numerically.
    function automatic void ref_encode(input bundle_t b, output logic [31:0] inst, output logic err);
        longint      s;
        logic [31:0] i;
        logic [31:0] lo;
        s  = longint'($signed(b.imm));
        i  = b.imm;
        lo = 32'(b.opc) | (32'(b.rd) << 7) | (32'(b.f3) << 12) | (32'(b.rs1) << 15);
        case (b.sel)
            3'd0: begin
                inst = lo | ((i & 32'hFFF) << 20);
                err  = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                inst = 32'(b.opc) | ((i & 32'd31) << 7) | (32'(b.f3) << 12) | (32'(b.rs1) << 15)
                     | (32'(b.rs2) << 20) | (((i >> 5) & 32'd127) << 25);
                err  = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                inst = 32'(b.opc) | (((i >> 11) & 32'd1) << 7) | (((i >> 1) & 32'd15) << 8)
                     | (32'(b.f3) << 12) | (32'(b.rs1) << 15) | (32'(b.rs2) << 20)
                     | (((i >> 5) & 32'd63) << 25) | (((i >> 12) & 32'd1) << 31);
                err  = (s < -4096) || (s > 4095) || ((i % 2) != 0);
            end
            3'd3: begin
                inst = 32'(b.opc) | (32'(b.rd) << 7) | (((i >> 12) & 32'd255) << 12)
                     | (((i >> 11) & 32'd1) << 20) | (((i >> 1) & 32'd1023) << 21)
                     | (((i >> 20) & 32'd1) << 31);
                err  = (s < -1048576) || (s > 1048575) || ((i % 2) != 0);
            end
            3'd4: begin
                inst = 32'(b.opc) | (32'(b.rd) << 7) | (i & 32'hFFFF_F000);
                err  = (i % 4096) != 0;
            end
            default: begin
                inst = lo | (32'(b.rs2) << 20) | (32'(b.f7) << 25);
                err  = 1'b0;
            end
        endcase
    endfunction

    function automatic bundle_t mk(input logic [2:0] sel, input logic [6:0] opc, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [31:0] imm);
        bundle_t b;
        b = '{sel: sel, opc: opc, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: 7'd0, imm: imm};
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b = bundle_t'({$urandom, $urandom, $urandom});
        b.sel = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: b.imm = 32'($signed($urandom_range(0, 12000)) - 6000);
            1: b.imm = $urandom & 32'hFFFF_F000;
            2: b.imm = $urandom & 32'h000F_FFFE;
            default: ;
        endcase
        return b;
    endfunction

    // Expected {in_ready, out_valid, out_inst, out_err, out_addr, err_cnt} from the model.
    function automatic logic [74:0] exp_vec();
        exp_t h;
        h = (exp_q.size() > 0) ? exp_q[0] : '0;
        return {exp_q.size() < 2, exp_q.size() > 0, h.inst, h.err, exp_addr, exp_errcnt};
    endfunction

    // Advance one clock edge and the model with it; inputs change 1 time unit later.
    task automatic cycle();
        bit   acc;
        bit   pop;
        exp_t e;
        acc = in_valid && (exp_q.size() < 2);
        pop = out_ready && (exp_q.size() > 0);
        e   = '0;
        if (acc) ref_encode(cur, e.inst, e.err);
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_addr   = 32'd0;
            exp_errcnt = 8'd0;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                exp_addr += 32'd4;
            end
            if (acc) begin
                exp_q.push_back(e);
                if (e.err && exp_errcnt != 8'hFF) exp_errcnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic push_one(input bundle_t b);
        cur = b; in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_inst !== 32'd0) $display("FAIL reset_out_inst got %h want 0", out_inst); else n_pass++;
        n_checks++; if (out_addr !== 32'd0) $display("FAIL reset_out_addr got %h want 0", out_addr); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %0b want 0", out_err); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %h want 0", err_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_directed();
        push_one(mk(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF));
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %0b want 1", out_valid); else n_pass++;
        n_checks++; if (out_inst !== 32'hFFF1_0093) $display("FAIL addi_inst got %h want fff10093", out_inst); else n_pass++;
        n_checks++; if (out_addr !== 32'd0) $display("FAIL addi_addr got %h want 0", out_addr); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL addi_err got %0b want 0", out_err); else n_pass++;
        pop_one();
        push_one(mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8));
        @(negedge clk);
        n_checks++; if (out_inst !== 32'h0020_8463) $display("FAIL beq_inst got %h want 00208463", out_inst); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL beq_err got %0b want 0", out_err); else n_pass++;
        n_checks++; if (out_addr !== 32'd4) $display("FAIL beq_addr got %h want 4", out_addr); else n_pass++;
        pop_one();
        push_one(mk(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800));
        @(negedge clk);
        n_checks++; if (out_inst !== 32'h0010_00EF) $display("FAIL jal_inst got %h want 001000ef", out_inst); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL jal_err got %0b want 0", out_err); else n_pass++;
        n_checks++; if (out_addr !== 32'd8) $display("FAIL jal_addr got %h want 8", out_addr); else n_pass++;
        pop_one();
    endtask

    task automatic test_range_errors();
        bundle_t     b[3];
        logic [31:0] w_inst;
        logic        w_err;
        b[0] = mk(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'd2048);
        b[1] = mk(3'd2, 7'h63, 5'd0, 5'd5, 5'd6, 3'd1, 32'd3);
        b[2] = mk(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'h0000_1001);
        for (int k = 0; k < 3; k++) begin
            push_one(b[k]);
            ref_encode(b[k], w_inst, w_err);
            @(negedge clk);
            n_checks++; if (out_err !== 1'b1) $display("FAIL range_err[%0d] got %0b want 1", k, out_err); else n_pass++;
            n_checks++; if (err_cnt !== 8'(k + 1)) $display("FAIL range_cnt[%0d] got %0d want %0d", k, err_cnt, k + 1); else n_pass++;
            n_checks++; if (out_inst !== w_inst) $display("FAIL range_inst[%0d] got %h want %h", k, out_inst, w_inst); else n_pass++;
            pop_one();
        end
    endtask

    task automatic test_backpressure();
        bundle_t     b[3];
        logic [31:0] w_inst;
        logic        w_err;
        int          k = 0;
        int          npop = 0;
        do_reset();
        for (int j = 0; j < 3; j++) b[j] = rand_bundle();
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cur = b[k];
            @(negedge clk);
            n_checks++;
            if (in_ready !== (c < 2)) $display("FAIL bp_in_ready[%0d] got %0b want %0b", c, in_ready, c < 2);
            else n_pass++;
            cycle();
            if (c < 2) k++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && npop < 3; c++) begin
            cur = b[k];
            in_valid = (k < 3);
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ref_encode(b[npop], w_inst, w_err);
                n_checks++;
                if (out_inst !== w_inst || out_addr !== 32'(4 * npop) || out_valid !== 1'b1)
                    $display("FAIL bp_order[%0d] got inst %h addr %h want inst %h addr %h", npop, out_inst, out_addr, w_inst, 32'(4 * npop));
                else n_pass++;
                npop++;
            end
            if (in_valid && exp_q.size() < 2) begin
                cycle(); k++;
            end else cycle();
        end
        n_checks++; if (npop != 3) $display("FAIL bp_drain popped %0d want 3", npop); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_one(rand_bundle());
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur = rand_bundle();
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_addr !== 32'(4 * i) || out_inst !== exp_q[0].inst)
                $display("FAIL b2b[%0d] got v%0b r%0b addr %h inst %h want v1 r1 addr %h inst %h",
                         i, out_valid, in_ready, out_addr, out_inst, 32'(4 * i), exp_q[0].inst);
            else n_pass++;
            cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [74:0] w;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cur = rand_bundle();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            w = exp_vec();
            n_checks++;
            if ({in_ready, out_valid, out_inst, out_err, out_addr, err_cnt} !== w)
                $display("FAIL random[%0d] got %h want %h", i, {in_ready, out_valid, out_inst, out_err, out_addr, err_cnt}, w);
            else n_pass++;
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_one(mk(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd5000));
        push_one(mk(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFF_0000));
        @(negedge clk);
        n_checks++; if (err_cnt !== 8'd2 || in_ready !== 1'b0) $display("FAIL mid_pre got cnt %0d rdy %0b want cnt 2 rdy 0", err_cnt, in_ready); else n_pass++;
        in_valid = 1'b1; reset = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_addr !== 32'd0) $display("FAIL mid_addr got %h want 0", out_addr); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL mid_err_cnt got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1 || out_inst !== 32'd0) $display("FAIL mid_idle got rdy %0b inst %h want rdy 1 inst 0", in_ready, out_inst); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [74:0] w;
        do_reset();
        cur = mk(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 270; i++) begin
            @(negedge clk);
            w = exp_vec();
            n_checks++;
            if ({in_ready, out_valid, out_inst, out_err, out_addr, err_cnt} !== w)
                $display("FAIL sat[%0d] got %h want %h", i, {in_ready, out_valid, out_inst, out_err, out_addr, err_cnt}, w);
            else n_pass++;
            cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (err_cnt !== 8'hFF) $display("FAIL sat_final got %h want ff", err_cnt); else n_pass++;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_range_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
